// File: rtl/grf_scoreboard_pkg.sv
// Shared constants for the GRF hazard scoreboard and the D-stage decoder:
// forwarding selects, Tuse/Tnew encodings and default pipeline latencies.
package grf_scoreboard_pkg;

  localparam int DEF_WB_LAT   = 3;
  localparam int DEF_MULT_LAT = 5;
  localparam int DEF_DIV_LAT  = 10;
  localparam int DEF_CW       = 4;

  typedef enum logic [1:0] {
    FWD_GRF = 2'd0,
    FWD_E   = 2'd1,
    FWD_M   = 2'd2
  } fwd_e;

  localparam logic [1:0] T_BR    = 2'd0;
  localparam logic [1:0] T_ALU   = 2'd1;
  localparam logic [1:0] T_ST    = 2'd2;
  localparam logic [1:0] TN_LINK = 2'd0;
  localparam logic [1:0] TN_ALU  = 2'd1;
  localparam logic [1:0] TN_LOAD = 2'd2;

  // wb counts the stages left before commit: 3 = in E, 2 = in M, 1 = in W,
  // and the GRF itself forwards a W-stage write to same-cycle readers.
  function automatic fwd_e wb_to_fwd(input logic [1:0] wb);
    fwd_e sel;
    case (wb)
      2'd3:    sel = FWD_E;
      2'd2:    sel = FWD_M;
      default: sel = FWD_GRF;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/grf_scoreboard_if.sv
// D-stage query/issue bundle between the decoder (master) and the GRF
// hazard scoreboard (slave).
interface grf_scoreboard_if;
  import grf_scoreboard_pkg::*;

  logic [4:0] src1;
  logic       src1_use;
  logic [1:0] src1_tuse;
  logic [4:0] src2;
  logic       src2_use;
  logic [1:0] src2_tuse;
  logic       issue_valid;
  logic [4:0] issue_rd;
  logic [1:0] issue_tnew;
  logic       md_start;
  logic       md_is_div;
  logic       md_use;
  logic       stall;
  fwd_e       fwd1;
  fwd_e       fwd2;
  logic       md_busy;

  modport master (
    output src1, src1_use, src1_tuse, src2, src2_use, src2_tuse,
    output issue_valid, issue_rd, issue_tnew, md_start, md_is_div, md_use,
    input  stall, fwd1, fwd2, md_busy
  );

  modport slave (
    input  src1, src1_use, src1_tuse, src2, src2_use, src2_tuse,
    input  issue_valid, issue_rd, issue_tnew, md_start, md_is_div, md_use,
    output stall, fwd1, fwd2, md_busy
  );

endinterface

// File: rtl/grf_scoreboard_sb_entry.sv
// One GPR's in-flight producer record: busy flag, cycles until forwardable
// (rdy) and cycles until GRF commit (wb).
module sb_entry
  import grf_scoreboard_pkg::*;
#(
  parameter int CW     = DEF_CW,
  parameter int WB_LAT = DEF_WB_LAT
) (
  input  logic          clk,
  input  logic          RESET,
  input  logic          load_i,
  input  logic [1:0]    tnew_i,
  output logic          busy_o,
  output logic [CW-1:0] rdy_o,
  output logic [1:0]    wb_o
);

  logic          busy_q, busy_d;
  logic [CW-1:0] rdy_q, rdy_d;
  logic [1:0]    wb_q, wb_d;

  // A new issue always replaces the record, even on the edge it would have
  // committed, so only the newest producer is ever tracked.
  always_comb begin
    busy_d = busy_q;
    rdy_d  = rdy_q;
    wb_d   = wb_q;
    if (load_i) begin
      busy_d = 1'b1;
      rdy_d  = CW'(tnew_i);
      wb_d   = 2'(WB_LAT);
    end else if (busy_q) begin
      rdy_d  = (rdy_q != '0) ? rdy_q - CW'(1) : '0;
      wb_d   = wb_q - 2'd1;
      busy_d = (wb_q != 2'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      busy_q <= 1'b0;
      rdy_q  <= '0;
      wb_q   <= 2'd0;
    end else begin
      busy_q <= busy_d;
      rdy_q  <= rdy_d;
      wb_q   <= wb_d;
    end
  end

  assign busy_o = busy_q;
  assign rdy_o  = rdy_q;
  assign wb_o   = wb_q;

endmodule

// File: rtl/grf_scoreboard.sv
// Decode-stage hazard controller: tracks newest GPR producers and the MDU
// busy window, and produces the D-stage stall and forwarding selects.
module grf_scoreboard
  import grf_scoreboard_pkg::*;
#(
  parameter int WB_LAT   = DEF_WB_LAT,
  parameter int MULT_LAT = DEF_MULT_LAT,
  parameter int DIV_LAT  = DEF_DIV_LAT,
  parameter int CW       = DEF_CW
) (
  input  logic             clk,
  input  logic             RESET,
  grf_scoreboard_if.slave  sb
);

  logic          busyArr [32];
  logic [CW-1:0] rdyArr  [32];
  logic [1:0]    wbArr   [32];
  logic [31:1]   loadVec;

  logic          hz1, hz2, hzmd, stall, issueOk;
  logic [CW-1:0] mdCnt_q, mdCnt_d;
  logic          mdBusy;

  // r0 is hardwired zero, so its slot reads as permanently idle.
  assign busyArr[0] = 1'b0;
  assign rdyArr[0]  = '0;
  assign wbArr[0]   = 2'd0;

  for (genvar r = 1; r < 32; r++) begin : g_entry
    sb_entry #(
      .CW     (CW),
      .WB_LAT (WB_LAT)
    ) u_entry (
      .clk    (clk),
      .RESET  (RESET),
      .load_i (loadVec[r]),
      .tnew_i (sb.issue_tnew),
      .busy_o (busyArr[r]),
      .rdy_o  (rdyArr[r]),
      .wb_o   (wbArr[r])
    );
  end

  assign mdBusy = (mdCnt_q != '0);

  // A source stalls only if its producer will not be forwardable by the
  // time the instruction actually needs the value.
  always_comb begin
    hz1  = sb.src1_use && (sb.src1 != 5'd0) && busyArr[sb.src1] &&
           (rdyArr[sb.src1] > CW'(sb.src1_tuse));
    hz2  = sb.src2_use && (sb.src2 != 5'd0) && busyArr[sb.src2] &&
           (rdyArr[sb.src2] > CW'(sb.src2_tuse));
    hzmd = sb.md_use && mdBusy;
    stall = hz1 || hz2 || hzmd;
  end

  always_comb begin
    sb.fwd1 = FWD_GRF;
    sb.fwd2 = FWD_GRF;
    if (busyArr[sb.src1] && !hz1) sb.fwd1 = wb_to_fwd(wbArr[sb.src1]);
    if (busyArr[sb.src2] && !hz2) sb.fwd2 = wb_to_fwd(wbArr[sb.src2]);
  end

  assign issueOk = sb.issue_valid && !stall && (sb.issue_rd != 5'd0);

  always_comb begin
    loadVec = '0;
    for (int r = 1; r < 32; r++) begin
      loadVec[r] = issueOk && (sb.issue_rd == 5'(r));
    end
  end

  // A stalled mult/div never leaves D, so it must not start the MDU window.
  always_comb begin
    mdCnt_d = mdCnt_q;
    if (sb.md_start && !stall) begin
      mdCnt_d = sb.md_is_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
    end else if (mdCnt_q != '0) begin
      mdCnt_d = mdCnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      mdCnt_q <= '0;
    end else begin
      mdCnt_q <= mdCnt_d;
    end
  end

  assign sb.stall   = stall;
  assign sb.md_busy = mdBusy;

endmodule
